caesar_stream_ctrl: RTL and testbench

- Sequencer that runs the Caesar shift datapath over a byte stream instead of one static letter selection.
- Loads a shift key and direction once per message, then streams ASCII bytes through a 2-stage registered shift pipeline with valid/ready backpressure.
- Sits between a byte source (UART/host FIFO) and a byte sink; owns message framing, key storage and a letter counter.

---
 rtl/caesar_stream_ctrl_if.sv | 31 +++
 rtl/caesar_stream_ctrl.sv | 151 +++++++++++++++
 tb/tb_caesar_stream_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/caesar_stream_ctrl_if.sv
// Stream/config bundle for caesar_stream_ctrl: key handshake, input byte stream, output byte
// stream and status.
interface caesar_stream_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [4:0]       cfg_key;
    logic             cfg_dec;
    logic             key_err;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_last;
    logic             busy;
    logic [CNT_W-1:0] char_cnt;

    modport master (
        output cfg_valid, cfg_key, cfg_dec, in_valid, in_data, in_last, out_ready,
        input  cfg_ready, key_err, in_ready, out_valid, out_data, out_last, busy, char_cnt
    );

    modport slave (
        input  cfg_valid, cfg_key, cfg_dec, in_valid, in_data, in_last, out_ready,
        output cfg_ready, key_err, in_ready, out_valid, out_data, out_last, busy, char_cnt
    );
endinterface

// File: rtl/caesar_stream_ctrl.sv
// Caesar shift over a framed byte stream: key/direction load, 2-stage valid/ready pipeline.
// Optional CAESAR_ROLLING_KEY_EN advances the key by 1 (mod 26) after each accepted letter.
module caesar_stream_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    caesar_stream_ctrl_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e           state_q, state_d;
    logic [4:0]       key_q;
    logic             dec_q;
    logic             s1_valid_q, s1_letter_q, s1_upper_q, s1_last_q;
    logic [7:0]       s1_data_q;
    logic [4:0]       s1_idx_q;
    logic             out_valid_q, out_letter_q, out_last_q;
    logic [7:0]       out_data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             key_err_q;
`ifdef CAESAR_ROLLING_KEY_EN
    logic [4:0]       s1_key_q;
`endif

    logic       cfg_fire, cfg_bad, s2_adv, in_ready, in_fire, out_fire;
    logic       in_upper, in_lower, in_letter;
    logic [4:0] in_idx, cur_key;
    logic [5:0] sum, diff, t6;
    logic [7:0] shifted;

    always_comb begin
        cfg_fire  = (state_q == StIdle) && bus.cfg_valid && (bus.cfg_key <= 5'd25);
        cfg_bad   = (state_q == StIdle) && bus.cfg_valid && (bus.cfg_key > 5'd25);
        s2_adv    = !out_valid_q || bus.out_ready;
        in_ready  = (state_q == StRun) && (!s1_valid_q || s2_adv);
        in_fire   = bus.in_valid && in_ready;
        out_fire  = out_valid_q && bus.out_ready;
        in_upper  = (bus.in_data >= 8'h41) && (bus.in_data <= 8'h5A);
        in_lower  = (bus.in_data >= 8'h61) && (bus.in_data <= 8'h7A);
        in_letter = in_upper || in_lower;
        // 'A' and 'a' both sit at offset 1 within their 32-byte block
        in_idx    = bus.in_data[4:0] - 5'd1;
    end

`ifdef CAESAR_ROLLING_KEY_EN
    assign cur_key = s1_key_q;
`else
    assign cur_key = key_q;
`endif

    always_comb begin
        sum  = {1'b0, s1_idx_q} + {1'b0, cur_key};
        diff = {1'b0, s1_idx_q} - {1'b0, cur_key};
        if (dec_q) begin
            t6 = diff[5] ? (diff + 6'd26) : diff;
        end else begin
            t6 = (sum >= 6'd26) ? (sum - 6'd26) : sum;
        end
        shifted = (s1_upper_q ? 8'h41 : 8'h61) + {3'b000, t6[4:0]};
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (cfg_fire) state_d = StRun;
            StRun:   if (in_fire && bus.in_last) state_d = StDrain;
            StDrain: if (out_fire && out_last_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q        <= '0;
            dec_q        <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_letter_q  <= 1'b0;
            s1_upper_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_data_q    <= '0;
            s1_idx_q     <= '0;
            out_valid_q  <= 1'b0;
            out_letter_q <= 1'b0;
            out_last_q   <= 1'b0;
            out_data_q   <= '0;
            cnt_q        <= '0;
            key_err_q    <= 1'b0;
`ifdef CAESAR_ROLLING_KEY_EN
            s1_key_q     <= '0;
`endif
        end else begin
            key_err_q <= cfg_bad;
            if (cfg_fire) begin
                key_q <= bus.cfg_key;
                dec_q <= bus.cfg_dec;
`ifdef CAESAR_ROLLING_KEY_EN
            end else if (in_fire && in_letter) begin
                key_q <= (key_q == 5'd25) ? 5'd0 : key_q + 5'd1;
`endif
            end

            if (in_fire) begin
                s1_valid_q  <= 1'b1;
                s1_data_q   <= bus.in_data;
                s1_idx_q    <= in_idx;
                s1_letter_q <= in_letter;
                s1_upper_q  <= in_upper;
                s1_last_q   <= bus.in_last;
`ifdef CAESAR_ROLLING_KEY_EN
                s1_key_q    <= key_q;
`endif
            end else if (s2_adv) begin
                s1_valid_q <= 1'b0;
            end

            // s2 only reloads when empty or its byte is leaving, so a stalled byte stays put
            if (s2_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q   <= s1_letter_q ? shifted : s1_data_q;
                    out_last_q   <= s1_last_q;
                    out_letter_q <= s1_letter_q;
                end
            end

            if (cfg_fire) begin
                cnt_q <= '0;
            end else if (out_fire && out_letter_q && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.cfg_ready = (state_q == StIdle);
    assign bus.busy      = (state_q != StIdle);
    assign bus.key_err   = key_err_q;
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.char_cnt  = cnt_q;
endmodule

// File: tb/tb_caesar_stream_ctrl.sv
// Directed self-checking bench for caesar_stream_ctrl; expected bytes are hand-computed.
module tb_caesar_stream_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    caesar_stream_ctrl_if #(.CNT_W(16)) bus ();

    caesar_stream_ctrl #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_acc_cyc = 0;
    int acc_count = 0;
    logic [7:0] q_data[$];
    logic       q_last[$];
    int         q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            q_data.push_back(bus.out_data);
            q_last.push_back(bus.out_last);
            q_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic clr_q();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic do_cfg(input logic [4:0] key, input logic dec);
        bus.cfg_valid = 1'b1;
        bus.cfg_key   = key;
        bus.cfg_dec   = dec;
        @(posedge clk);
        #1;
        bus.cfg_valid = 1'b0;
    endtask

    task automatic send_msg(input string s, input bit last_en, output bit ok);
        bit acc;
        ok = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            acc = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = s[i];
            bus.in_last  = last_en && (i == s.len() - 1);
            for (int n = 0; n < 200 && !acc; n++) begin
                @(negedge clk);
                acc = bus.in_ready;
                if (acc) begin
                    acc_count++;
                    if (i == 0) first_acc_cyc = cyc;
                end
                @(posedge clk);
                #1;
            end
            if (!acc) begin
                ok = 1'b0;
                break;
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_out(input int n, output bit ok);
        for (int k = 0; k < 300 && q_data.size() < n; k++) begin
            @(posedge clk);
            #1;
        end
        ok = (q_data.size() >= n);
    endtask

    task automatic run_msg(input logic [4:0] key, input logic dec, input string s, output bit ok);
        bit ok1, ok2;
        clr_q();
        do_cfg(key, dec);
        send_msg(s, 1'b1, ok1);
        wait_out(s.len(), ok2);
        ok = ok1 && ok2;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.cfg_valid = 1'b0;
        bus.cfg_key   = '0;
        bus.cfg_dec   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.cfg_ready, bus.in_ready, bus.out_valid, bus.busy, bus.key_err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got rdy/in/ov/busy/err=%b expected 10000",
                     {bus.cfg_ready, bus.in_ready, bus.out_valid, bus.busy, bus.key_err});
        end
        checks++;
        if (bus.out_data !== 8'h00 || bus.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got data=%h last=%b expected 00/0", bus.out_data, bus.out_last);
        end
        checks++;
        if (bus.char_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d expected 0", bus.char_cnt);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got rdy=%b busy=%b in_rdy=%b expected 1/0/0",
                     bus.cfg_ready, bus.busy, bus.in_ready);
        end
    endtask

    task automatic test_encrypt();
        bit ok;
        string expd;
`ifdef CAESAR_ROLLING_KEY_EN
        expd = "Km, e";
`else
        expd = "Kl, c";
`endif
        run_msg(5'd3, 1'b0, "Hi, z", ok);
        checks++;
        if (!ok || q_data.size() != 5) begin
            errors++;
            $display("FAIL enc_count got %0d bytes expected 5", q_data.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (q_data[i] !== expd[i] || q_last[i] !== (i == 4)) begin
                    errors++;
                    $display("FAIL enc_byte%0d got %h last=%b expected %h last=%b",
                             i, q_data[i], q_last[i], expd[i], (i == 4));
                end
            end
            checks++;
            if (q_cyc[0] - first_acc_cyc != 2) begin
                errors++;
                $display("FAIL enc_latency got %0d expected 2", q_cyc[0] - first_acc_cyc);
            end
        end
        checks++;
        if (bus.char_cnt !== 16'd3 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL enc_end got cnt=%0d busy=%b rdy=%b expected 3/0/1",
                     bus.char_cnt, bus.busy, bus.cfg_ready);
        end
    endtask

    task automatic test_decrypt();
        logic [4:0] keys[5] = '{5'd3, 5'd25, 5'd0, 5'd1, 5'd1};
        logic       decs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        string      ins[5]  = '{"aA", "b", "Q", "zZ", "Aa"};
`ifdef CAESAR_ROLLING_KEY_EN
        string      exps[5] = '{"xW", "a", "Q", "aB", "Zy"};
`else
        string      exps[5] = '{"xX", "a", "Q", "aA", "Zz"};
`endif
        bit ok;
        string e;
        for (int v = 0; v < 5; v++) begin
            run_msg(keys[v], decs[v], ins[v], ok);
            e = exps[v];
            checks++;
            if (!ok || q_data.size() != e.len()) begin
                errors++;
                $display("FAIL vec%0d_count got %0d expected %0d", v, q_data.size(), e.len());
            end else begin
                for (int i = 0; i < e.len(); i++) begin
                    checks++;
                    if (q_data[i] !== e[i]) begin
                        errors++;
                        $display("FAIL vec%0d_byte%0d got %h expected %h", v, i, q_data[i], e[i]);
                    end
                end
            end
            checks++;
            if (bus.char_cnt !== 16'(e.len())) begin
                errors++;
                $display("FAIL vec%0d_cnt got %0d expected %0d", v, bus.char_cnt, e.len());
            end
        end
    endtask

    task automatic test_key_err();
        bit ok1, ok2;
        clr_q();
        do_cfg(5'd26, 1'b0);
        checks++;
        if (bus.key_err !== 1'b1 || bus.cfg_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL keyerr_pulse got err=%b rdy=%b busy=%b expected 1/1/0",
                     bus.key_err, bus.cfg_ready, bus.busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.key_err !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL keyerr_once got err=%b busy=%b expected 0/0", bus.key_err, bus.busy);
        end
        do_cfg(5'd1, 1'b0);
        checks++;
        if (bus.busy !== 1'b1 || bus.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL keyerr_accept got busy=%b rdy=%b expected 1/0", bus.busy, bus.cfg_ready);
        end
        // a second cfg while running must not change the key
        do_cfg(5'd5, 1'b1);
        send_msg("a", 1'b1, ok1);
        wait_out(1, ok2);
        checks++;
        if (!ok1 || !ok2 || q_data[0] !== 8'h62) begin
            errors++;
            $display("FAIL cfg_ignored got %h expected 62", ok2 ? q_data[0] : 8'hxx);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bit ok1, ok2;
        int a0;
        logic [7:0] hold;
        string expd;
`ifdef CAESAR_ROLLING_KEY_EN
        expd = "bdfhjl";
`else
        expd = "bcdefg";
`endif
        clr_q();
        do_cfg(5'd1, 1'b0);
        fork
            send_msg("abcdef", 1'b1, ok1);
            begin
                for (int n = 0; n < 300 && q_data.size() < 2; n++) begin
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b0;
                a0 = acc_count;
                hold = bus.out_data;
                checks++;
                if (bus.out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_valid got %b expected 1", bus.out_valid);
                end
                repeat (5) begin
                    @(posedge clk);
                    #1;
                    checks++;
                    if (bus.out_valid !== 1'b1 || bus.out_data !== hold) begin
                        errors++;
                        $display("FAIL bp_stable got v=%b d=%h expected 1/%h",
                                 bus.out_valid, bus.out_data, hold);
                    end
                end
                checks++;
                if (bus.in_ready !== 1'b0 || acc_count - a0 > 2) begin
                    errors++;
                    $display("FAIL bp_inready got in_rdy=%b accepts=%0d expected 0/<=2",
                             bus.in_ready, acc_count - a0);
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_out(6, ok2);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (!ok1 || q_data.size() != 6) begin
            errors++;
            $display("FAIL bp_count got %0d expected 6", q_data.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (q_data[i] !== expd[i]) begin
                    errors++;
                    $display("FAIL bp_byte%0d got %h expected %h", i, q_data[i], expd[i]);
                end
            end
        end
    endtask

    task automatic test_rolling();
        bit ok;
        string expd;
`ifdef CAESAR_ROLLING_KEY_EN
        expd = "bc-d";
`else
        expd = "bb-b";
`endif
        run_msg(5'd1, 1'b0, "aa-a", ok);
        checks++;
        if (!ok || q_data.size() != 4) begin
            errors++;
            $display("FAIL roll_count got %0d expected 4", q_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (q_data[i] !== expd[i]) begin
                    errors++;
                    $display("FAIL roll_byte%0d got %h expected %h", i, q_data[i], expd[i]);
                end
            end
        end
        checks++;
        if (bus.char_cnt !== 16'd3) begin
            errors++;
            $display("FAIL roll_cnt got %0d expected 3", bus.char_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clr_q();
        do_cfg(5'd1, 1'b0);
        send_msg("ab", 1'b0, ok);
        checks++;
        if (!ok || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_inflight got ok=%b ov=%b expected 1/1", ok, bus.out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_async got ov=%b busy=%b rdy=%b expected 0/0/1",
                     bus.out_valid, bus.busy, bus.cfg_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h63;
        repeat (6) begin
            @(posedge clk);
            #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL mid_quiet got ov=%b in_rdy=%b expected 0/0",
                         bus.out_valid, bus.in_ready);
            end
        end
        bus.in_valid = 1'b0;
        checks++;
        if (q_data.size() != 0) begin
            errors++;
            $display("FAIL mid_stale got %0d outputs expected 0", q_data.size());
        end
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_key_err();
        test_backpressure();
        test_rolling();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
